// File: rtl/uart_msg_tx_if.sv
// Byte handshake between the message sequencer and the uart_tx serialiser.
interface uart_msg_tx_if;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy;

    modport master (output tx_data, output tx_send, input tx_busy);
    modport slave  (input tx_data, input tx_send, output tx_busy);
endinterface

// File: rtl/uart_msg_tx.sv
// Streams one message from a compile-time table into uart_tx, with optional
// CR/LF append, gap-separated repeat and abort after the byte in flight.
module uart_msg_tx #(
    parameter int unsigned                   NUM_MSG     = 2,
    parameter int unsigned                   MAX_LEN     = 16,
    parameter logic [NUM_MSG*MAX_LEN*8-1:0]  MSGS        = '0,
    parameter logic [NUM_MSG*8-1:0]          LENS        = '0,
    parameter bit                            APPEND_CRLF = 1'b1,
    parameter int unsigned                   GAP_CYCLES  = 0,
    localparam int unsigned                  SEL_W       = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SEL_W-1:0]   sel,
    input  logic               repeat_en,
    input  logic               abort,
    output logic               ready,
    output logic               done,
    output logic               aborted,
    output logic               err,
    uart_msg_tx_if.master      tx
);

    localparam logic [8:0]  CRLF_ADD = APPEND_CRLF ? 9'd2 : 9'd0;
    localparam logic [23:0] GAP_LOAD = (GAP_CYCLES == 0) ? 24'd0 : 24'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_ACK   = 3'd2,
        ST_ADV   = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    state_e             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [7:0]         len_q;
    logic [8:0]         idx_q;
    logic [23:0]        gap_q;
    logic               ready_q;
    logic               done_q;
    logic               aborted_q;
    logic               err_q;
    logic [7:0]         tx_data_q;
    logic               tx_send_q;

    logic               sel_ok_d;
    logic [7:0]         sel_len_d;
    logic [8:0]         sel_tot_d;
    logic [8:0]         tot_d;
    logic [8:0]         idx_next_d;
    logic [7:0]         cur_byte_d;

    // Payload bytes first, then the CR/LF trailer positions past the payload.
    function automatic logic [7:0] byte_at(input logic [SEL_W-1:0] s,
                                           input logic [8:0]       k,
                                           input logic [7:0]       len);
        logic [7:0] b;
        if (k < {1'b0, len}) begin
            b = MSGS[8*(32'(s)*MAX_LEN + 32'(k)) +: 8];
        end else if (k == {1'b0, len}) begin
            b = 8'h0D;
        end else begin
            b = 8'h0A;
        end
        return b;
    endfunction

    // Request decode for IDLE and byte/length arithmetic for the active run.
    always_comb begin
        sel_ok_d  = (32'(sel) < NUM_MSG);
        sel_len_d = 8'h00;
        if (sel_ok_d) begin
            sel_len_d = LENS[8*32'(sel) +: 8];
        end else begin
            sel_len_d = 8'h00;
        end
        sel_tot_d  = {1'b0, sel_len_d} + CRLF_ADD;
        tot_d      = {1'b0, len_q} + CRLF_ADD;
        idx_next_d = idx_q + 9'd1;
        cur_byte_d = byte_at(sel_q, idx_q, len_q);
    end

    // Sequencer state and every registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            len_q     <= 8'h00;
            idx_q     <= 9'd0;
            gap_q     <= 24'd0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
            tx_data_q <= 8'h00;
            tx_send_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (!sel_ok_d) begin
                            err_q <= 1'b1;
                        end else if (sel_tot_d == 9'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            sel_q   <= sel;
                            len_q   <= sel_len_d;
                            idx_q   <= 9'd0;
                            ready_q <= 1'b0;
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (abort) begin
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                        ready_q   <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else if (!tx.tx_busy) begin
                        tx_data_q <= cur_byte_d;
                        tx_send_q <= 1'b1;
                        state_q   <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (tx.tx_busy) begin
                        tx_send_q <= 1'b0;
                        state_q   <= ST_ADV;
                    end
                end
                ST_ADV: begin
                    if (idx_next_d < tot_d) begin
                        if (abort) begin
                            done_q    <= 1'b1;
                            aborted_q <= 1'b1;
                            ready_q   <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            idx_q   <= idx_next_d;
                            state_q <= ST_ISSUE;
                        end
                    end else if (repeat_en && !abort) begin
                        idx_q <= 9'd0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= ST_ISSUE;
                        end else begin
                            gap_q   <= GAP_LOAD;
                            state_q <= ST_GAP;
                        end
                    end else begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                        ready_q   <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else if (gap_q == 24'd0) begin
                        state_q <= ST_ISSUE;
                    end else begin
                        gap_q <= gap_q - 24'd1;
                    end
                end
                default: begin
                    tx_send_q <= 1'b0;
                    ready_q   <= 1'b1;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign err        = err_q;
    assign tx.tx_data = tx_data_q;
    assign tx.tx_send = tx_send_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Randomised self-checking bench for uart_msg_tx with a behavioural uart_tx
// busy model and a string-table reference for the expected byte stream.
module tb_uart_msg_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start, repeat_en, abort;
    logic [0:0] sel;
    logic       ready, done, aborted, err;
    uart_msg_tx_if tx_a ();

    logic       z_start;
    logic [1:0] z_sel;
    logic       z_ready, z_done, z_aborted, z_err;
    uart_msg_tx_if tx_z ();

    localparam logic [127:0] MSGS_A = {40'h0, 24'h525245, 48'h0, 16'h4B4F};
    localparam logic [15:0]  LENS_A = 16'h0302;
    localparam logic [95:0]  MSGS_Z = {24'h0, 8'h41, 8'h0, 24'h525245, 32'h0};
    localparam logic [23:0]  LENS_Z = 24'h010300;
    localparam int GAP = 5;

    uart_msg_tx #(.NUM_MSG(2), .MAX_LEN(8), .MSGS(MSGS_A), .LENS(LENS_A),
                  .APPEND_CRLF(1'b1), .GAP_CYCLES(GAP)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .repeat_en(repeat_en),
        .abort(abort), .ready(ready), .done(done), .aborted(aborted), .err(err), .tx(tx_a));

    uart_msg_tx #(.NUM_MSG(3), .MAX_LEN(4), .MSGS(MSGS_Z), .LENS(LENS_Z),
                  .APPEND_CRLF(1'b0), .GAP_CYCLES(0)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .start(z_start), .sel(z_sel), .repeat_en(1'b0),
        .abort(1'b0), .ready(z_ready), .done(z_done), .aborted(z_aborted), .err(z_err), .tx(tx_z));

    int total = 0;
    int bad   = 0;

    // uart_tx stand-in: busy rises the cycle after send is seen, lasts busy_len clocks.
    int busy_len = 10;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        else if (tx_a.tx_send) busy_cnt <= busy_len;
    end
    assign tx_a.tx_busy = (busy_cnt > 0);
    assign tx_z.tx_busy = 1'b0;

    logic [7:0] got_q[$];
    int         rise_cyc[$];
    logic [7:0] exp_q[$];
    int cyc = 0, done_cnt = 0, abrt_cnt = 0, err_cnt = 0, z_send_cnt = 0;
    logic       prev_send = 1'b0;
    logic [7:0] held = 8'h00;

    // Monitor, sampled 2 ns after each rising edge.
    always begin
        @(posedge clk);
        #2;
        cyc++;
        if (tx_a.tx_send && !prev_send) begin
            got_q.push_back(tx_a.tx_data);
            rise_cyc.push_back(cyc);
            held = tx_a.tx_data;
        end else if (tx_a.tx_send) begin
            total++;
            if (tx_a.tx_data !== held) begin
                bad++;
                $display("FAIL data_stable: tx_data=%h while send held, want %h", tx_a.tx_data, held);
            end
        end
        if (aborted) begin
            total++;
            if (done !== 1'b1) begin
                bad++;
                $display("FAIL abort_with_done: done=%b when aborted=1, want 1", done);
            end
        end
        if (done) done_cnt++;
        if (aborted) abrt_cnt++;
        if (err) err_cnt++;
        if (tx_z.tx_send) z_send_cnt++;
        prev_send = tx_a.tx_send;
    end

    string msg_tab [2] = '{"OK", "ERR"};

    function automatic void push_msg(input int s);
        for (int k = 0; k < msg_tab[s].len(); k++) exp_q.push_back(msg_tab[s][k]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    task automatic clear_mon();
        got_q.delete();
        rise_cyc.delete();
        exp_q.delete();
        done_cnt = 0;
        abrt_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic do_start(input logic s);
        @(negedge clk);
        sel   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_link_idle();
        for (int i = 0; i < 40; i++) begin
            if (!tx_a.tx_busy) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sel = 1'b0; repeat_en = 1'b0; abort = 1'b0;
        z_start = 1'b0; z_sel = 2'd0;
        repeat (3) @(negedge clk);
        total++;
        if ({ready, done, aborted, err, tx_a.tx_send} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_flags: rdy/done/abt/err/send=%b, want 10000",
                     {ready, done, aborted, err, tx_a.tx_send});
        end
        total++;
        if (tx_a.tx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: tx_data=%h, want 00", tx_a.tx_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({ready, tx_a.tx_send, z_ready} !== 3'b101) begin
            bad++;
            $display("FAIL reset_release: rdy/send/z_rdy=%b, want 101", {ready, tx_a.tx_send, z_ready});
        end
    endtask

    task automatic test_single();
        bit ok;
        int s, sp;
        for (int n = 0; n < 4; n++) begin
            s = (n == 0) ? 1 : int'($urandom_range(0, 1));
            busy_len = (n == 0) ? 10 : int'($urandom_range(1, 12));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wait_link_idle();
            clear_mon();
            push_msg(s);
            do_start(1'(s));
            total++;
            if ({ready, tx_a.tx_send} !== 2'b00) begin
                bad++;
                $display("FAIL single_accept: rdy/send=%b one cycle after start, want 00", {ready, tx_a.tx_send});
            end
            @(negedge clk);
            total++;
            if (tx_a.tx_send !== 1'b1) begin
                bad++;
                $display("FAIL single_first_send: tx_send=%b two cycles after start, want 1", tx_a.tx_send);
            end
            wait_done(400, ok);
            total++;
            if (!ok || ready !== 1'b1) begin
                bad++;
                $display("FAIL single_done: done seen=%0d ready=%b, want 1 and 1", ok, ready);
            end
            total++;
            if (got_q.size() != exp_q.size() || done_cnt != 1 || abrt_cnt != 0) begin
                bad++;
                $display("FAIL single_counts: bytes=%0d done=%0d aborted=%0d, want %0d 1 0",
                         got_q.size(), done_cnt, abrt_cnt, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL single_byte%0d: got %h, want %h", i, got_q[i], exp_q[i]);
                end
            end
            sp = (busy_len + 2 > 4) ? busy_len + 2 : 4;
            for (int i = 1; i < rise_cyc.size(); i++) begin
                total++;
                if (rise_cyc[i] - rise_cyc[i-1] != sp) begin
                    bad++;
                    $display("FAIL single_spacing%0d: %0d clocks, want %0d", i, rise_cyc[i] - rise_cyc[i-1], sp);
                end
            end
        end
    endtask

    task automatic test_err();
        @(negedge clk);
        z_sel   = 2'd3;
        z_start = 1'b1;
        @(negedge clk);
        z_start = 1'b0;
        total++;
        if ({z_err, z_ready, z_done} !== 3'b110) begin
            bad++;
            $display("FAIL err_pulse: err/rdy/done=%b, want 110", {z_err, z_ready, z_done});
        end
        @(negedge clk);
        total++;
        if ({z_err, z_ready} !== 2'b01 || z_send_cnt != 0) begin
            bad++;
            $display("FAIL err_after: err/rdy=%b sends=%0d, want 01 0", {z_err, z_ready}, z_send_cnt);
        end
    endtask

    task automatic test_zero();
        @(negedge clk);
        z_sel   = 2'd0;
        z_start = 1'b1;
        @(negedge clk);
        z_start = 1'b0;
        total++;
        if ({z_done, z_ready, z_aborted} !== 3'b110) begin
            bad++;
            $display("FAIL zero_done: done/rdy/abt=%b, want 110", {z_done, z_ready, z_aborted});
        end
        @(negedge clk);
        total++;
        if (z_done !== 1'b0 || z_send_cnt != 0) begin
            bad++;
            $display("FAIL zero_after: done=%b sends=%0d, want 0 0", z_done, z_send_cnt);
        end
    endtask

    task automatic test_repeat();
        bit ok;
        int k, sp;
        busy_len = 1;
        k = int'($urandom_range(2, 3));
        wait_link_idle();
        clear_mon();
        for (int r = 0; r < k; r++) push_msg(0);
        repeat_en = 1'b1;
        do_start(1'b0);
        for (int i = 0; i < 600; i++) begin
            if (got_q.size() >= 4 * k) break;
            @(negedge clk);
        end
        repeat_en = 1'b0;
        wait_done(200, ok);
        total++;
        if (!ok || done_cnt != 1 || abrt_cnt != 0 || got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL repeat_end: done seen=%0d done=%0d aborted=%0d bytes=%0d, want 1 1 0 %0d",
                     ok, done_cnt, abrt_cnt, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL repeat_byte%0d: got %h, want %h", i, got_q[i], exp_q[i]);
            end
        end
        for (int i = 1; i < rise_cyc.size(); i++) begin
            sp = (i % 4 == 0) ? 4 + GAP : 4;
            total++;
            if (rise_cyc[i] - rise_cyc[i-1] != sp) begin
                bad++;
                $display("FAIL repeat_spacing%0d: %0d clocks, want %0d", i, rise_cyc[i] - rise_cyc[i-1], sp);
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        int n;
        for (int t = 0; t < 3; t++) begin
            busy_len = 10;
            n = (t == 0) ? 2 : int'($urandom_range(0, 4));
            wait_link_idle();
            clear_mon();
            push_msg(1);
            do_start(1'b1);
            for (int i = 0; i < 200; i++) begin
                if (got_q.size() >= n) break;
                @(negedge clk);
            end
            abort = 1'b1;
            wait_done(100, ok);
            total++;
            if (!ok || aborted !== 1'b1) begin
                bad++;
                $display("FAIL abort_done: done seen=%0d aborted=%b, want 1 1", ok, aborted);
            end
            abort = 1'b0;
            repeat (20) @(negedge clk);
            total++;
            if (got_q.size() != n || abrt_cnt != 1 || done_cnt != 1) begin
                bad++;
                $display("FAIL abort_counts: bytes=%0d aborted=%0d done=%0d, want %0d 1 1",
                         got_q.size(), abrt_cnt, done_cnt, n);
            end
            for (int i = 0; i < n && i < got_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL abort_byte%0d: got %h, want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        busy_len = int'($urandom_range(1, 5));
        wait_link_idle();
        clear_mon();
        push_msg(0);
        push_msg(1);
        do_start(1'b0);
        wait_done(200, ok);
        sel   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (!ok || ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept: first done=%0d ready=%b, want 1 0", ok, ready);
        end
        wait_done(300, ok);
        total++;
        if (!ok || done_cnt != 2 || got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL b2b_counts: done seen=%0d done=%0d bytes=%0d, want 1 2 %0d",
                     ok, done_cnt, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b_byte%0d: got %h, want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        busy_len = 10;
        wait_link_idle();
        clear_mon();
        do_start(1'b1);
        for (int i = 0; i < 50; i++) begin
            if (tx_a.tx_send) break;
            @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({tx_a.tx_send, ready, done} !== 3'b010) begin
            bad++;
            $display("FAIL midreset: send/rdy/done=%b, want 010", {tx_a.tx_send, ready, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_link_idle();
        clear_mon();
        push_msg(0);
        do_start(1'b0);
        wait_done(200, ok);
        total++;
        if (!ok || got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL midreset_rerun: done seen=%0d bytes=%0d, want 1 %0d", ok, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL midreset_byte%0d: got %h, want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_err();
        test_zero();
        test_repeat();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_msg_tx.md
# uart_msg_tx

Parametrised UART message sequencer. It holds a compile-time table of NUM_MSG messages and streams a selected one, byte by byte, into the existing `uart_tx` serialiser over its send/busy handshake. Optional features are CR/LF append, continuous repeat with a programmable inter-message gap, and abort. It sits between board-level control logic (buttons, status FSMs) and `uart_tx` on the FTDI link.

## Interface
Parameters:
- NUM_MSG, 2: number of messages in the table, ≥1.
- MAX_LEN, 16: slot size in bytes per message, 1..255.
- MSGS, 0: packed NUM_MSG*MAX_LEN*8 bits. Byte k of message i is MSGS[8*(i*MAX_LEN+k) +: 8]; byte 0 is sent first.
- LENS, 0: packed NUM_MSG*8 bits. Length of message i is LENS[8*i +: 8], range 0..MAX_LEN.
- APPEND_CRLF, 1: when 1, 0x0D then 0x0A are sent after every message.
- GAP_CYCLES, 0: idle clocks between repetitions in repeat mode, 0..2^24-1.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low. Clock is `clk`, reset is `rst_n`.
- clk  in  1  system clock (100 MHz on ULX3S).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only in a cycle where ready=1.
- sel  in  SEL_W=max(1,$clog2(NUM_MSG))  message index, sampled on accept.
- repeat_en  in  1  sampled at each message end; 1 means restart the same message.
- abort  in  1  level; stop after the byte currently in flight.
- ready  out  1  high while IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- aborted  out  1  high together with done when the run ended by abort.
- err  out  1  one-cycle pulse when start is rejected because sel ≥ NUM_MSG.
- tx_data  out  8  byte to `uart_tx` idata; stable while tx_send=1.
- tx_send  out  1  to `uart_tx` send.
- tx_busy  in  1  from `uart_tx` busy.

## Operation
- States: IDLE, ISSUE, ACK, ADV, GAP. All outputs are registered.
- Reset values: state=IDLE, ready=1, done=0, aborted=0, err=0, tx_send=0, tx_data=0x00, byte index=0, gap counter=0.
- Total length TOT = len + 2·APPEND_CRLF, 9-bit arithmetic.
- Byte select at index idx: idx<len gives MSGS byte; idx==len gives 0x0D; idx==len+1 gives 0x0A.
- IDLE:
  - If start and sel≥NUM_MSG: pulse err, stay in IDLE.
  - If start and TOT==0: pulse done, stay in IDLE.
  - Else latch sel and len, idx=0, ready←0, go to ISSUE.
- ISSUE:
  - If abort: done=1, aborted=1, go to IDLE. Nothing is sent.
  - Else, when tx_busy=0: tx_data←byte(idx), tx_send←1, go to ACK.
  - Else wait.
- ACK: hold tx_send=1 until tx_busy=1 is sampled, then tx_send←0, go to ADV. The byte is committed; abort does not cancel it.
- ADV:
  - If idx+1<TOT and !abort: idx++, go to ISSUE.
  - If idx+1<TOT and abort: aborted=1, finish.
  - If idx+1==TOT: if repeat_en and !abort, idx←0 and go to GAP (GAP_CYCLES>0) or ISSUE (GAP_CYCLES==0); else finish.
- GAP: count GAP_CYCLES clocks, then go to ISSUE. abort in GAP finishes with aborted=1.
- Finish: done=1 for one cycle, ready←1, state IDLE.
- Table is read-only; latched sel/len are immune to sel changes mid-run.
- rst_n low mid-run: immediate return to reset values. tx_send drops asynchronously; `uart_tx` may complete its current frame.

## Timing
- Accept at edge T gives ready=0 at T+1 and ISSUE at T+1. tx_send=1 at T+2 if tx_busy=0.
- tx_send deasserts the cycle after tx_busy=1 is first sampled.
- Per-byte overhead beyond the `uart_tx` frame: 2 clocks (ADV, ISSUE wait on busy low).
- done and aborted pulse in the same cycle that ready returns high. A start in the following cycle is accepted.
- GAP: exactly GAP_CYCLES clocks between ADV of the last byte and ISSUE of the first byte.

## Test plan
Bench setup: NUM_MSG=2, MAX_LEN=8, msg0="OK" (len 2), msg1="ERR" (len 3), APPEND_CRLF=1. The `uart_tx` model raises busy 1 cycle after send and holds it for 10 cycles.

- Reset, then start with sel=1 → tx_data sequence 0x45, 0x52, 0x52, 0x0D, 0x0A; 5 tx_send handshakes; one done pulse; aborted=0; ready=1 after.
- sel=2 with start → err pulse for 1 cycle; ready stays 1; tx_send never asserts.
- sel=0, repeat_en=1, GAP_CYCLES=5 → "OK\r\n" repeated. Exactly 5 idle clocks in GAP between 0x0A ADV and the next ISSUE. Dropping repeat_en ends after the current 0x0A with done.
- sel=1, abort asserted while the 2nd byte is in ACK → 0x52 completes and no 3rd byte is sent; done=1 and aborted=1 in the same cycle.
- LENS[0]=0, APPEND_CRLF=0 build, start sel=0 → done pulse the cycle after start; no tx_send.
- rst_n low during ACK → tx_send=0 and ready=1 immediately. A start after release sends the message from byte 0.
